fifo_sc_flex: RTL
=================

// Module: fifo_sc_flex
// PURPOSE
//  Single-clock FIFO, successor to the power-of-2 FIFO. Supports any depth >= 2, runtime-programmable
//  almost thresholds, level output, synchronous flush and sticky overflow/underflow flags.
//  Optional packet mode adds commit/discard. Used between Soc bus peripherals (UART, SPI, DMA) and their cores.
// PARAMETERS
//  WIDTH       8  data width in bits, >=1
//  DEPTH       6  storage entries, any integer >=2; no rounding up to a power of 2
//  SHOW_AHEAD  1  1: q shows the head entry ahead of ren; 0: q loads on an accepted read
//  CNT_W       localparam $clog2(DEPTH+1); width of level and threshold ports
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset: asynchronous, active-high
//  flush      in   1        synchronous clear of contents
//  wen        in   1        write request
//  wdata      in   WIDTH    write data
//  ren        in   1        read request
//  q          out  WIDTH    read data
//  level      out  CNT_W    number of readable (committed) entries
//  afull_th   in   CNT_W    almost-full threshold; 0 disables
//  aempty_th  in   CNT_W    almost-empty threshold; 0 disables
//  almost_full, full, almost_empty, empty   out 1   status flags
//  overflow   out  1        sticky: a wen was rejected
//  underflow  out  1        sticky: a ren was rejected
//  err_clr    in   1        clears overflow/underflow
//  wcommit    in   1        packet commit (FIFO_SC_FLEX_PKT_EN only)
//  wdiscard   in   1        packet discard (FIFO_SC_FLEX_PKT_EN only)
// BEHAVIOUR
//  Reset: ptrs=0, level=0, q=0, empty=1, full=0, overflow=underflow=0. almost_* follow level.
//  Pointers count 0..DEPTH-1 and wrap to 0 by explicit compare. No modulo-2^n wrap.
//  rd_ok = ren && !empty.
//  wr_ok = wen && (!full || rd_ok). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
//  level: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur. full = (level==DEPTH). empty = (level==0).
//  almost_full  = afull_th!=0  && level>=afull_th. Never asserts when afull_th>DEPTH.
//  almost_empty = aempty_th!=0 && level<=aempty_th. Flags are combinational from registered state.
//  SHOW_AHEAD=1: whenever empty=0, q equals the oldest entry in the same cycle.
//   - Write into an empty FIFO: q valid at edge+1 together with empty=0.
//   - After rd_ok, q advances to the next entry at edge+1.
//  SHOW_AHEAD=0: on rd_ok, q <= head entry (1-cycle latency). Otherwise q holds its value.
//  Empty FIFO with simultaneous wen+ren: write accepted, read rejected, underflow set.
//  overflow  <= 1 on wen && !wr_ok. underflow <= 1 on ren && !rd_ok.
//  err_clr clears both flags. A new error in the same cycle as err_clr wins (flag stays 1).
//  flush: highest priority. wen/ren that cycle are ignored, ptrs and level go to 0.
//  flush does not change q, overflow or underflow.
// CONFIGURATION
//  `define FIFO_SC_FLEX_PKT_EN: packet mode.
//   - Adds a speculative write ptr and uncommitted count. full uses committed+uncommitted entries.
//   - level, empty, almost_* and reads see committed entries only.
//   - wcommit publishes all uncommitted entries, including a write accepted in the same cycle.
//   - wdiscard rewinds the write ptr to the commit ptr and drops a same-cycle write. discard wins over commit.
//   - flush clears uncommitted entries.
//  Without the macro: wcommit/wdiscard ports exist but are ignored. Every write is committed immediately.
// STRUCTURE
//  Package fifo_flex_pkg: function cnt_w(depth) and typedef fifo_err_t {overflow, underflow}.
//  Sub-module fifo_wrap_ptr #(DEPTH): ptr register with inc, load and clear inputs, wrapping at DEPTH-1.
//  Used for the read, write and (packet mode) commit pointers.
//  Storage is an unreset register array, written on wr_ok.
// TESTING
//  1) DEPTH=6: write 1..6 -> full=1, level=6. Read 6 times -> q=1..6 in order, empty=1. Repeat twice to cross the 5->0 wrap.
//  2) Full, then wen+ren with wdata=0xAA -> level stays 6, overflow=0. 0xAA is read last.
//  3) Empty, ren=1 -> underflow=1, level=0. err_clr -> 0. err_clr plus a new bad ren -> stays 1.
//  4) afull_th=4, aempty_th=1: level 1 -> almost_empty=1. level 4 -> almost_full=1. th=0 -> both 0.
//  5) level=3, flush with wen=1 -> level=0, empty=1 next cycle. overflow is unchanged.
//  6) PKT_EN: write 3, wdiscard -> level 0. Write 2 plus a same-cycle wcommit on the 2nd -> level 2, q=first word.
//  7) Async rst asserted mid-burst -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// Shared helpers for the flexible-depth single-clock FIFO.
// Provides the level/threshold width function and the sticky error flag pair.
package fifo_flex_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Pointer register counting 0..DEPTH-1 with explicit wrap back to 0.
// Priority: clr over load over inc; ptr_inc_o is the wrapped successor of the current value.
module fifo_wrap_ptr #(
    parameter int DEPTH = 6,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    input  logic          inc,
    output logic [PW-1:0] ptr_o,
    output logic [PW-1:0] ptr_inc_o
);

    logic [PW-1:0] ptr_q, ptr_d;

    assign ptr_inc_o = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_o     = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_inc_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fifo_sc_flex.sv
// Single-clock FIFO of arbitrary depth with programmable almost flags and sticky errors.
// Define FIFO_SC_FLEX_PKT_EN to enable packet commit/discard on the write side.
module fifo_sc_flex
    import fifo_flex_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 6,
    parameter int SHOW_AHEAD = 1,
    localparam int CNT_W     = cnt_w(DEPTH),
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] level,
    input  logic [CNT_W-1:0] afull_th,
    input  logic [CNT_W-1:0] aempty_th,
    output logic             almost_full,
    output logic             full,
    output logic             almost_empty,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr,
    input  logic             wcommit,
    input  logic             wdiscard
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, rd_ptr_inc, wr_ptr, wr_ptr_inc;
    logic [CNT_W-1:0] level_q, level_d;
    fifo_err_t        err_q, err_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             rd_ok, wr_ok, wr_keep, full_int;
    logic             wr_load;
    logic [PW-1:0]    wr_load_val;
    logic             unused_ptr;

`ifdef FIFO_SC_FLEX_PKT_EN
    logic [CNT_W-1:0] unc_q, unc_d;
    logic [PW-1:0]    cm_ptr, unused_cm_inc;
    logic             cm_load;
    logic [PW-1:0]    cm_val;

    // Capacity counts speculative entries too; readers only see committed ones.
    assign full_int    = (CNT_W'(level_q + unc_q) == CNT_W'(DEPTH));
    assign wr_keep     = wr_ok && !wdiscard;
    assign wr_load     = !flush && wdiscard;
    assign wr_load_val = cm_ptr;
    assign cm_load     = !flush && wcommit && !wdiscard;
    assign cm_val      = wr_keep ? wr_ptr_inc : wr_ptr;

    always_comb begin
        level_d = level_q;
        unc_d   = unc_q;
        if (flush) begin
            level_d = '0;
            unc_d   = '0;
        end else begin
            level_d = level_q - CNT_W'(rd_ok);
            if (wdiscard) begin
                unc_d = '0;
            end else if (wcommit) begin
                level_d = level_d + unc_q + CNT_W'(wr_keep);
                unc_d   = '0;
            end else begin
                unc_d = unc_q + CNT_W'(wr_keep);
            end
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_cm_ptr (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (cm_load),
        .load_val  (cm_val),
        .inc       (1'b0),
        .ptr_o     (cm_ptr),
        .ptr_inc_o (unused_cm_inc)
    );

    assign unused_ptr = &{1'b0, unused_cm_inc, rd_ptr_inc};
`else
    assign full_int    = (level_q == CNT_W'(DEPTH));
    assign wr_keep     = wr_ok;
    assign wr_load     = 1'b0;
    assign wr_load_val = '0;

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            level_d = level_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        end
    end

    // Packet controls are present on the port list but have no effect here.
    assign unused_ptr = &{1'b0, wcommit, wdiscard, wr_ptr_inc, rd_ptr_inc};
`endif

    assign empty = (level_q == '0);
    assign full  = full_int;
    assign level = level_q;
    assign rd_ok = !flush && ren && !empty;
    assign wr_ok = !flush && wen && (!full_int || rd_ok);

    assign almost_full  = (afull_th != '0) && (level_q >= afull_th);
    assign almost_empty = (aempty_th != '0) && (level_q <= aempty_th);

    always_comb begin
        err_d.overflow  = (err_q.overflow && !err_clr) || (!flush && wen && !wr_ok);
        err_d.underflow = (err_q.underflow && !err_clr) || (!flush && ren && !rd_ok);
    end

    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (1'b0),
        .load_val  ('0),
        .inc       (rd_ok),
        .ptr_o     (rd_ptr),
        .ptr_inc_o (rd_ptr_inc)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .load      (wr_load),
        .load_val  (wr_load_val),
        .inc       (wr_keep),
        .ptr_o     (wr_ptr),
        .ptr_inc_o (wr_ptr_inc)
    );

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Show-ahead holds the last shown head while empty so flush leaves q untouched.
    always_comb begin
        q_d = q_q;
        if (SHOW_AHEAD != 0) begin
            if (!empty) begin
                q_d = mem[rd_ptr];
            end
        end else if (rd_ok) begin
            q_d = mem[rd_ptr];
        end
    end

    assign q = (SHOW_AHEAD != 0) ? q_d : q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            err_q   <= '0;
            q_q     <= '0;
`ifdef FIFO_SC_FLEX_PKT_EN
            unc_q   <= '0;
`endif
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
            q_q     <= q_d;
`ifdef FIFO_SC_FLEX_PKT_EN
            unc_q   <= unc_d;
`endif
        end
    end

endmodule
